// File: rtl/tt_capture_pkg.sv
// rtl/tt_capture_pkg.sv - shared types and defaults for the capture sequencer
package tt_capture_pkg;

    localparam int DEF_DIV_W   = 8;
    localparam int DEF_BURST_W = 4;

    typedef enum logic [1:0] {
        MODE_IDLE   = 2'b00,
        MODE_FREE   = 2'b01,
        MODE_STROBE = 2'b10,
        MODE_BURST  = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FREE   = 3'd1,
        S_STROBE = 3'd2,
        S_ARM    = 3'd3,
        S_BURST  = 3'd4,
        S_DONE   = 3'd5
    } state_e;

    // Resting state for each configured mode; BURST rests in S_ARM waiting for start.
    function automatic state_e mode_to_state(input mode_e m);
        case (m)
            MODE_FREE:   return S_FREE;
            MODE_STROBE: return S_STROBE;
            MODE_BURST:  return S_ARM;
            default:     return S_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/tt_capture_divider.sv
// rtl/tt_capture_divider.sv - programmable tick counter (tick every i_div+1 clocks) with clear
module tt_capture_divider
    import tt_capture_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tick
);

    logic [DIV_W-1:0] r_count;

    // >= rather than == so a divisor lowered below the running count wraps at once.
    assign o_tick = (r_count >= i_div);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear || o_tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/tt_capture_sequencer.sv
// rtl/tt_capture_sequencer.sv - capture-register sequencer (free/strobe/burst); CAPTURE_XOR_EN selects delta capture
module tt_capture_sequencer
    import tt_capture_pkg::*;
#(
    parameter int DIV_W   = DEF_DIV_W,
    parameter int BURST_W = DEF_BURST_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         cfg_mode,
    input  logic [DIV_W-1:0]   cfg_div,
    input  logic [BURST_W-1:0] cfg_len,
    input  logic               start,
    input  logic               strobe,
    input  logic [7:0]         din,
    output logic [7:0]         dout,
    output logic               load,
    output logic               busy,
    output logic               done
);

    localparam logic [BURST_W-1:0] LEN_ONE = BURST_W'(1);

    state_e             r_state;
    state_e             w_next;
    logic [DIV_W-1:0]   r_div;
    logic [BURST_W-1:0] r_rem;
    logic               r_strobe_d;
    mode_e              w_mode;
    logic [DIV_W-1:0]   w_div;
    logic               w_tick;
    logic               w_rise;
    logic               w_clear;
    logic               w_capture;
    logic               w_start_burst;

    assign w_mode  = mode_e'(cfg_mode);
    assign w_rise  = strobe & ~r_strobe_d;
    // A running burst uses the divisor latched at start, not the live input.
    assign w_div   = (r_state == S_BURST) ? r_div : cfg_div;
    assign w_clear = (r_state == S_IDLE) | w_start_burst;

    tt_capture_divider #(
        .DIV_W (DIV_W)
    ) u_divider (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_clear),
        .i_div   (w_div),
        .o_tick  (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_capture     = 1'b0;
        w_start_burst = 1'b0;
        busy          = (r_state == S_BURST);
        done          = (r_state == S_DONE);
        case (r_state)
            S_IDLE: begin
                w_next = mode_to_state(w_mode);
            end
            S_FREE: begin
                w_capture = w_tick;
                w_next    = mode_to_state(w_mode);
            end
            S_STROBE: begin
                w_capture = w_rise;
                w_next    = mode_to_state(w_mode);
            end
            S_ARM: begin
                // A mode change in the same cycle as start wins; no burst is launched.
                if (w_mode != MODE_BURST) begin
                    w_next = mode_to_state(w_mode);
                end else if (start) begin
                    w_start_burst = 1'b1;
                    w_next        = S_BURST;
                end
            end
            S_BURST: begin
                w_capture = w_tick;
                if (w_tick && (r_rem <= LEN_ONE)) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_ARM;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout       <= 8'h00;
            load       <= 1'b0;
            r_rem      <= '0;
            r_div      <= '0;
            r_strobe_d <= 1'b0;
        end else begin
            load       <= w_capture;
            r_strobe_d <= strobe;
            if (w_capture) begin
`ifdef CAPTURE_XOR_EN
                dout <= din ^ dout;
`else
                dout <= din;
`endif
            end
            if (w_start_burst) begin
                r_rem <= (cfg_len == '0) ? LEN_ONE : cfg_len;
                r_div <= cfg_div;
            end else if (w_capture && (r_state == S_BURST)) begin
                r_rem <= r_rem - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tt_capture_sequencer.sv
// tb/tb_tt_capture_sequencer.sv - scoreboard bench for tt_capture_sequencer
module tb_tt_capture_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] cfg_mode = 2'b00;
    logic [7:0] cfg_div = 8'd0;
    logic [3:0] cfg_len = 4'd0;
    logic       start = 1'b0;
    logic       strobe = 1'b0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic       load;
    logic       busy;
    logic       done;

    typedef struct {
        int         cyc;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   base = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tt_capture_sequencer #(
        .DIV_W   (8),
        .BURST_W (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_mode (cfg_mode),
        .cfg_div  (cfg_div),
        .cfg_len  (cfg_len),
        .start    (start),
        .strobe   (strobe),
        .din      (din),
        .dout     (dout),
        .load     (load),
        .busy     (busy),
        .done     (done)
    );

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%b required=%b", name, cyc - base, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%02h required=%02h", name, cyc - base, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic expect_load(input int c, input logic [7:0] d);
        exp_t e;
        e.cyc  = c;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string name);
        chki(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (load === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_load cycle=%0d actual=%02h required=no_load", cyc - base, dout);
            end else begin
                mon_e = exp_q.pop_front();
                chk8("load_data", dout, mon_e.data);
                chki("load_cycle", cyc, mon_e.cyc);
            end
        end
    end

    initial begin
        #22 rst_n = 1'b1;
        chk8("reset_dout", dout, 8'h00);
        chk1("reset_load", load, 1'b0);
        chk1("reset_busy", busy, 1'b0);
        chk1("reset_done", done, 1'b0);
        step();

        // FREE, divisor 3: capture every 4th edge
        base = cyc;
        cfg_mode = 2'b01; cfg_div = 8'd3; din = 8'h10;
        expect_load(base + 5, 8'h14);
        expect_load(base + 9, 8'h18);
        expect_load(base + 13, 8'h1C);
        for (int k = 1; k <= 13; k++) begin
            step();
            din = 8'(8'h10 + k);
        end
        cfg_mode = 2'b00;
        step(); step();
        drain("free_drain");

        // STROBE held high 5 cycles: one capture
        base = cyc;
        cfg_mode = 2'b10; din = 8'hA5; strobe = 1'b0;
        expect_load(base + 2, 8'hA5);
        for (int k = 1; k <= 7; k++) begin
            step();
            strobe = (k <= 5);
        end
        cfg_mode = 2'b00;
        step(); step();
        drain("strobe_drain");
        chk8("strobe_dout", dout, 8'hA5);

        // BURST len 3 div 1, then len 0 (one sample)
        base = cyc;
        cfg_mode = 2'b11; cfg_div = 8'd1; cfg_len = 4'd3; din = 8'h40; start = 1'b0;
        expect_load(base + 4, 8'h43);
        expect_load(base + 6, 8'h45);
        expect_load(base + 8, 8'h47);
        expect_load(base + 12, 8'h4B);
        for (int k = 1; k <= 16; k++) begin
            step();
            chk1("burst_busy", busy, (k >= 2 && k <= 7) || (k >= 10 && k <= 11));
            chk1("burst_done", done, (k == 8) || (k == 12));
            din = 8'(8'h40 + k);
            start = (k == 1) || (k == 9);
            cfg_len = (k >= 9) ? 4'd0 : 4'd3;
        end
        drain("burst_drain");

        // Mid-burst mode/len/div change: burst completes with latched config, then FREE
        base = cyc;
        cfg_len = 4'd2; cfg_div = 8'd0; start = 1'b1; din = 8'h80;
        expect_load(base + 2, 8'h81);
        expect_load(base + 3, 8'h82);
        expect_load(base + 9, 8'h88);
        expect_load(base + 15, 8'h8E);
        for (int k = 1; k <= 16; k++) begin
            step();
            chk1("midchg_busy", busy, (k >= 1 && k <= 2));
            chk1("midchg_done", done, (k == 3));
            start = 1'b0;
            din = 8'(8'h80 + k);
            if (k == 1) begin
                cfg_mode = 2'b01; cfg_len = 4'd15; cfg_div = 8'd5;
            end
        end
        cfg_mode = 2'b00;
        step(); step();
        drain("midchg_drain");

        // Reset mid-cycle right after the second burst sample
        base = cyc;
        cfg_mode = 2'b11; cfg_len = 4'd3; cfg_div = 8'd1; din = 8'hC0;
        expect_load(base + 4, 8'hC3);
        for (int k = 1; k <= 6; k++) begin
            step();
            chk1("abort_busy_pre", busy, (k >= 2));
            chk1("abort_done_pre", done, 1'b0);
            din = 8'(8'hC0 + k);
            start = (k == 1);
        end
        #2 rst_n = 1'b0;
        #1;
        chk8("async_reset_dout", dout, 8'h00);
        chk1("async_reset_load", load, 1'b0);
        chk1("async_reset_busy", busy, 1'b0);
        chk1("async_reset_done", done, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk1("abort_busy_post", busy, 1'b0);
            chk1("abort_done_post", done, 1'b0);
        end
        chk8("abort_dout_hold", dout, 8'h00);
        drain("abort_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tt_capture_sequencer.md
Name: tt_capture_sequencer

Overview:
Controller that sequences the Tiny Tapeout 8-bit input-capture register, i.e. decides when ui_in is sampled into the uo_out holding register.
- Modes: free-run, external-strobe, and counted burst with programmable decimation.
- Sits between the top-level pins and the capture register; drives its load enable and reports status on uio_out.

Parameters:
- DIV_W, 8, width of decimation divider (sample every DIV+1 clocks).
- BURST_W, 4, width of burst-length counter (1..2^BURST_W-1 samples; 0 treated as 1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cfg_mode  input  2  00=IDLE hold, 01=FREE run, 10=STROBE, 11=BURST.
- cfg_div  input  DIV_W  decimation divisor minus one.
- cfg_len  input  BURST_W  burst sample count.
- start  input  1  pulse; arms a burst (BURST mode only).
- strobe  input  1  external sample request, async to nothing (already synchronous to clk).
- din  input  8  data to capture (ui_in).
- dout  output  8  captured data register.
- load  output  1  one-cycle pulse coincident with dout update.
- busy  output  1  high while a burst is in progress.
- done  output  1  one-cycle pulse after final burst sample.

Behaviour:
- Reset (async, rst_n low): dout=0, load=0, busy=0, done=0, divider=0, burst count=0, FSM=S_IDLE. Release is synchronous to next clk edge.
- Capture latency: a qualifying sample event at edge N updates dout at edge N (registered din), load high during cycle after edge N.
- Divider: counts 0..cfg_div, generates tick when count==cfg_div then wraps to 0; cfg_div=0 means tick every cycle. Divider free-runs in FREE; cleared in IDLE and on burst start.
- FSM states: S_IDLE, S_FREE, S_STROBE, S_ARM, S_BURST, S_DONE.
- S_IDLE: no captures; dout holds. Move to S_FREE/S_STROBE per cfg_mode; BURST mode goes to S_ARM.
- S_FREE: capture on each divider tick.
- S_STROBE: capture on rising edge of strobe (edge-detected with 1 flop, strobe held high = one capture); divider ignored.
- S_ARM: wait for start; on start -> S_BURST, load remaining=max(cfg_len,1), divider=0, busy=1.
- S_BURST: capture on each tick, decrement remaining; on last capture -> S_DONE.
- S_DONE: done=1 for exactly one cycle, busy=0, return to S_ARM.
- cfg_mode change: sampled every cycle; change takes effect next cycle except in S_BURST, which completes the burst first (cfg_len/cfg_div latched at start, not re-read).
- start during S_BURST/S_DONE ignored. start and mode change same cycle in S_ARM: mode wins (go to new mode, no burst).
- Reset mid-burst: aborts immediately, no done pulse.

Optional Feature:
- CAPTURE_XOR_EN: when defined, dout <= din ^ dout_prev on capture (delta mode, change detection); parity flag ORed into done not affected. Without it, dout <= din plain capture.

Decomposition:
- Package tt_capture_pkg: mode enum (MODE_IDLE/FREE/STROBE/BURST), FSM state enum, default DIV_W/BURST_W constants.
- One sub-module natural: tt_capture_divider (programmable tick counter with clear).

Test Plan:
- Reset: assert rst_n low mid-cycle -> dout=0x00, busy=0, load=0 immediately without clock edge.
- FREE, cfg_div=3, din ramps 0x10.. -> load every 4th cycle, dout takes din value at those edges.
- STROBE: strobe held high 5 cycles with din=0xA5 -> exactly one load, dout=0xA5.
- BURST, cfg_len=3, cfg_div=1, start pulse -> busy 6 cycles, three loads 2 cycles apart, done one cycle after third; cfg_len=0 -> one load.
- Mid-burst cfg_mode->FREE and cfg_len change -> burst still yields original count, then FREE.
- Reset asserted during burst at sample 2 -> busy=0, no done, FSM in S_IDLE after release.
